// File: rtl/dffsync_mux_pipe.sv
// dffsync_mux_pipe: M-way input select feeding a DEPTH-stage valid/ready register pipeline.
// Define DFFSYNC_MUX_PIPE_PARITY_EN to add a per-stage even-parity bit with parity_o/parity_err_o.
module dffsync_mux_pipe #(
  parameter int unsigned N     = 5,
  parameter int unsigned M     = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned VAL   = 31,
  localparam int unsigned SW   = (M > 1) ? $clog2(M) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [M*N-1:0] data_i,
  input  logic [SW-1:0]  sel_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic           clr_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [N-1:0]   data_o,
  output logic [CW-1:0]  count_o
`ifdef DFFSYNC_MUX_PIPE_PARITY_EN
  ,
  output logic           parity_o,
  output logic           parity_err_o
`endif
);

  localparam logic [N-1:0] ValN = N'(VAL);

  logic [N-1:0]     selWord;
  logic [N-1:0]     stageData_q [DEPTH];
  logic [N-1:0]     stageData_d [DEPTH];
  logic [DEPTH-1:0] stageValid_q;
  logic [DEPTH-1:0] stageValid_d;
  logic [DEPTH-1:0] adv;
  logic             accept;

  // Out-of-range selects (M not a power of two) fall back to the reset value.
  always_comb begin
    selWord = ValN;
    for (int k = 0; k < int'(M); k++) begin
      if (int'(sel_i) == k) selWord = data_i[k*N +: N];
    end
  end

  // A stage may move forward when it is empty or the stage after it moves forward.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = ~stageValid_q[DEPTH-1] | out_ready_i;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      adv[k] = ~stageValid_q[k] | adv[k+1];
    end
  end

  assign in_ready_o = adv[0];
  assign accept     = in_valid_i & adv[0] & ~clr_i;

  always_comb begin
    stageData_d  = stageData_q;
    stageValid_d = stageValid_q;
    if (clr_i) begin
      for (int k = 0; k < int'(DEPTH); k++) stageData_d[k] = ValN;
      stageValid_d = '0;
    end else begin
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (adv[k]) begin
          stageData_d[k]  = stageData_q[k-1];
          stageValid_d[k] = stageValid_q[k-1];
        end
      end
      // Stage 0 drains without an accept by dropping its valid; its data is simply held.
      if (adv[0]) begin
        stageValid_d[0] = accept;
        if (accept) stageData_d[0] = selWord;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < int'(DEPTH); k++) stageData_q[k] <= ValN;
      stageValid_q <= '0;
    end else begin
      stageData_q  <= stageData_d;
      stageValid_q <= stageValid_d;
    end
  end

  always_comb begin
    count_o = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      count_o = count_o + CW'(stageValid_q[k]);
    end
  end

  assign out_valid_o = stageValid_q[DEPTH-1];
  assign data_o      = stageData_q[DEPTH-1];

`ifdef DFFSYNC_MUX_PIPE_PARITY_EN
  localparam logic ValParity = ^ValN;

  logic [DEPTH-1:0] stageParity_q;
  logic [DEPTH-1:0] stageParity_d;

  // Parity travels alongside the data using the same advance enables.
  always_comb begin
    stageParity_d = stageParity_q;
    if (clr_i) begin
      stageParity_d = {DEPTH{ValParity}};
    end else begin
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (adv[k]) stageParity_d[k] = stageParity_q[k-1];
      end
      if (accept) stageParity_d[0] = ^selWord;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stageParity_q <= {DEPTH{ValParity}};
    end else begin
      stageParity_q <= stageParity_d;
    end
  end

  assign parity_o     = stageParity_q[DEPTH-1];
  assign parity_err_o = out_valid_o & (parity_o != ^data_o);
`endif

endmodule

// File: tb/tb_dffsync_mux_pipe.sv
// tb_dffsync_mux_pipe: directed stimulus with a queue scoreboard on the DEPTH=2 instance,
// plus directed bubble-collapse checks on a DEPTH=3 instance.
module tb_dffsync_mux_pipe;

  logic clk = 1'b0;
  logic rstN;

  // Free-running clock, period 10
  always #5 clk = ~clk;

  logic [19:0] dataIn;
  logic [1:0]  sel;
  logic        inValid, inReady, clr, outValid, outReady;
  logic [4:0]  dataOut;
  logic [1:0]  count;

  logic [19:0] dataIn3;
  logic [1:0]  sel3;
  logic        inValid3, inReady3, clr3, outValid3, outReady3;
  logic [4:0]  dataOut3;
  logic [1:0]  count3;

`ifdef DFFSYNC_MUX_PIPE_PARITY_EN
  logic parity, parityErr, parity3, parityErr3;
`endif

  dffsync_mux_pipe #(.N(5), .M(4), .DEPTH(2), .VAL(31)) dut (
    .clk_i(clk), .rst_i(rstN), .data_i(dataIn), .sel_i(sel),
    .in_valid_i(inValid), .in_ready_o(inReady), .clr_i(clr),
    .out_valid_o(outValid), .out_ready_i(outReady), .data_o(dataOut), .count_o(count)
`ifdef DFFSYNC_MUX_PIPE_PARITY_EN
    , .parity_o(parity), .parity_err_o(parityErr)
`endif
  );

  dffsync_mux_pipe #(.N(5), .M(4), .DEPTH(3), .VAL(31)) dut3 (
    .clk_i(clk), .rst_i(rstN), .data_i(dataIn3), .sel_i(sel3),
    .in_valid_i(inValid3), .in_ready_o(inReady3), .clr_i(clr3),
    .out_valid_o(outValid3), .out_ready_i(outReady3), .data_o(dataOut3), .count_o(count3)
`ifdef DFFSYNC_MUX_PIPE_PARITY_EN
    , .parity_o(parity3), .parity_err_o(parityErr3)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [4:0] expQ [$];
  logic [4:0] expWord;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One cycle of stimulus: inputs set after a rising edge, handshake judged at the falling edge.
  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic rdy, input logic c,
                               input logic [4:0] word, output logic accepted, output logic readySeen);
    inValid  = v;
    sel      = s;
    outReady = rdy;
    clr      = c;
    @(negedge clk);
    readySeen = inReady;
    accepted  = v && inReady && !c;
    if (accepted) expQ.push_back(word);
    @(posedge clk);
    #1;
    if (c) expQ.delete();
  endtask

  // Monitor: every output handshake pops the oldest expected word.
  always @(negedge clk) begin
    if (rstN && !clr && outValid && outReady) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedWord: got %0d expected none", dataOut);
      end else begin
        expWord = expQ.pop_front();
        checkOutput("scoreboardData", 32'(dataOut), 32'(expWord));
      end
    end
  end

  // Directed sequence covering reset, select/latency, backpressure, clear, async reset and bubbles
  initial begin
    logic acc, rs;
    rstN      = 1'b0;
    inValid   = 1'b0; sel  = 2'd0; outReady  = 1'b0; clr  = 1'b0;
    inValid3  = 1'b0; sel3 = 2'd0; outReady3 = 1'b0; clr3 = 1'b0;
    dataIn    = {5'd4, 5'd3, 5'd2, 5'd1};
    dataIn3   = {5'd4, 5'd3, 5'd2, 5'd1};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetData", 32'(dataOut), 32'd31);
    checkOutput("resetValid", 32'(outValid), 32'd0);
    checkOutput("resetCount", 32'(count), 32'd0);
`ifdef DFFSYNC_MUX_PIPE_PARITY_EN
    checkOutput("resetParity", 32'(parity), 32'd1);
`endif
    rstN = 1'b1;
    #1;
    checkOutput("resetInReady", 32'(inReady), 32'd1);

    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0, 5'd3, acc, rs);
    checkOutput("latValidEarly", 32'(outValid), 32'd0);
    checkOutput("latCount", 32'(count), 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 5'd0, acc, rs);
    checkOutput("latValid", 32'(outValid), 32'd1);
    checkOutput("latData", 32'(dataOut), 32'd3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'(i), 1'b1, 1'b0, 5'(i + 1), acc, rs);
      checkOutput("b2bAccept", 32'(acc), 32'd1);
    end
    repeat (3) applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 5'd0, acc, rs);
    checkOutput("b2bDrained", 32'(expQ.size()), 32'd0);
    checkOutput("b2bIdleValid", 32'(outValid), 32'd0);

    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 5'd1, acc, rs);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 5'd2, acc, rs);
    checkOutput("bpCountFull", 32'(count), 32'd2);
    checkOutput("bpInReady", 32'(inReady), 32'd0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 5'd3, acc, rs);
    checkOutput("bpHeld", 32'(acc), 32'd0);
    checkOutput("bpStableData", 32'(dataOut), 32'd1);
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0, 5'd3, acc, rs);
    checkOutput("bpSimulAccept", 32'(acc), 32'd1);
    checkOutput("bpSimulCount", 32'(count), 32'd2);
    checkOutput("bpNextData", 32'(dataOut), 32'd2);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, acc, rs);
    repeat (3) applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 5'd0, acc, rs);
    checkOutput("bpDrained", 32'(expQ.size()), 32'd0);

    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 5'd1, acc, rs);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 5'd2, acc, rs);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b1, 5'd4, acc, rs);
    checkOutput("clrInReady", 32'(rs), 32'd1);
    checkOutput("clrCount", 32'(count), 32'd0);
    checkOutput("clrData", 32'(dataOut), 32'd31);
    checkOutput("clrValid", 32'(outValid), 32'd0);
    repeat (3) applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 5'd0, acc, rs);
    checkOutput("clrNotDelivered", 32'(outValid), 32'd0);

    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 5'd2, acc, rs);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 5'd3, acc, rs);
    inValid = 1'b0;
    #2 rstN = 1'b0;
    #1;
    checkOutput("asyncRstValid", 32'(outValid), 32'd0);
    checkOutput("asyncRstCount", 32'(count), 32'd0);
    checkOutput("asyncRstData", 32'(dataOut), 32'd31);
    expQ.delete();
    @(posedge clk);
    #1 rstN = 1'b1;
    #1;

    dataIn = {5'd4, 5'd3, 5'd2, 5'b00111};
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0, 5'd7, acc, rs);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, acc, rs);
    checkOutput("parWordValid", 32'(outValid), 32'd1);
    checkOutput("parWordData", 32'(dataOut), 32'd7);
`ifdef DFFSYNC_MUX_PIPE_PARITY_EN
    checkOutput("parityBit", 32'(parity), 32'd1);
    checkOutput("parityErr", 32'(parityErr), 32'd0);
`endif
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 5'd0, acc, rs);
    checkOutput("finalDrained", 32'(expQ.size()), 32'd0);

    sel3 = 2'd1; inValid3 = 1'b1; outReady3 = 1'b0;
    @(posedge clk); #1;
    inValid3 = 1'b0;
    checkOutput("bubCount1", 32'(count3), 32'd1);
    checkOutput("bubValidStage0", 32'(outValid3), 32'd0);
    @(posedge clk); #1;
    checkOutput("bubValidStage1", 32'(outValid3), 32'd0);
    checkOutput("bubReadyStage1", 32'(inReady3), 32'd1);
    @(posedge clk); #1;
    checkOutput("bubValidLast", 32'(outValid3), 32'd1);
    checkOutput("bubDataLast", 32'(dataOut3), 32'd2);
    sel3 = 2'd2; inValid3 = 1'b1;
    @(posedge clk); #1;
    checkOutput("bubCount2", 32'(count3), 32'd2);
    checkOutput("bubReady2", 32'(inReady3), 32'd1);
    sel3 = 2'd3;
    @(posedge clk); #1;
    inValid3 = 1'b0;
    checkOutput("bubCount3", 32'(count3), 32'd3);
    checkOutput("bubReadyFull", 32'(inReady3), 32'd0);
    checkOutput("bubHeadHeld", 32'(dataOut3), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dffsync_mux_pipe.md
Name: dffsync_mux_pipe

Overview:
Parametrised successor of the two-input selectable reset-to-value register.
- Selects one of M data inputs and pushes the word through a DEPTH-stage register pipeline with valid/ready flow control.
- Each stage has its own valid flag, and a stage accepts data only when the stage after it is empty or advancing.
- Intended as a generic registered input-select or stall-tolerant delay line in datapaths that previously chained single select registers.

Parameters:
N, 5, data width in bits
M, 4, number of selectable data inputs (M >= 2)
DEPTH, 2, number of pipeline stages (DEPTH >= 1)
VAL, 31, N-bit value loaded into every stage data register on reset or clear

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous, active-low reset; all stages to VAL, all valids to 0
data_i  input  M*N  packed inputs; input k occupies bits [k*N+N-1 : k*N]
sel_i  input  $clog2(M)  input select, sampled when a word is accepted
in_valid_i  input  1  upstream word present
in_ready_o  output  1  block can accept a word this cycle
clr_i  input  1  synchronous clear: all stage data to VAL, all valids to 0
out_valid_o  output  1  last stage holds a valid word
out_ready_i  input  1  downstream accepts the word
data_o  output  N  last-stage data register
count_o  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
Reset (rst_i = 0, asynchronous):
- stage data = VAL; stage valids = 0.
- out_valid_o = 0, data_o = VAL, count_o = 0, in_ready_o = 1 once released.

Select:
- Selected word = data_i slice sel_i.
- sel_i >= M (M not a power of 2) selects VAL.

Stage advance, stage k = 0..DEPTH-1, last stage = DEPTH-1:
- adv[DEPTH-1] = !v[DEPTH-1] | out_ready_i.
- adv[k] = !v[k] | adv[k+1] for lower stages. This is combinational ripple; no registered skid.
- in_ready_o = adv[0].

Transfers:
- Input accept = in_valid_i & in_ready_o. Stage 0 loads the selected word and v[0] <= 1.
- If stage 0 advances without an accept, v[0] <= 0 and its data is held.
- Stage k+1 loads stage k data when adv[k+1]. Then v[k+1] <= v[k].
- An invalid stage may load bubble data. Data of a stage with valid = 0 is don't-care, except after reset or clear, when it is VAL.
- Output transfer = out_valid_o & out_ready_i.

Latency and throughput:
- Unstalled, a word accepted at edge t appears at data_o with out_valid_o = 1 after edge t+DEPTH-1. This is DEPTH registers, DEPTH cycles input-to-output.
- One word per cycle sustained when out_ready_i = 1.

Bubble collapse:
- With out_ready_i = 0, words compact toward the output.
- in_ready_o falls only when all DEPTH stages are valid.

Full, simultaneous in and out:
- With all stages valid and out_ready_i = 1, in_ready_o = 1.
- Accept and output happen in the same cycle. count_o is unchanged.

count_o:
- count_o = popcount of the valids.
- It changes by at most 1 per cycle, except on clear or reset.

clr_i:
- Has priority over all transfers.
- The input is not accepted in a clear cycle, although in_ready_o is still driven by the advance logic. Upstream must not treat that cycle as a handshake.
- Next cycle: count_o = 0, data_o = VAL.

Reset mid-operation:
- Asynchronous reset immediately forces the reset values above.
- In-flight words are discarded.

Stability:
- out_valid_o and data_o must be held while out_valid_o & !out_ready_i.
- Upstream holds data_i and sel_i stable while in_valid_i & !in_ready_o.

Optional Feature:
DFFSYNC_MUX_PIPE_PARITY_EN
- Defined:
  - Each stage stores an extra even-parity bit computed from the selected word at accept.
  - Adds output parity_o (1 bit), the last-stage parity bit. Reset and clear value = ^VAL.
  - Adds output parity_err_o (1 bit) = out_valid_o & (parity_o != ^data_o).
- Undefined: the ports are absent; no extra storage.

Test Plan:
- Reset value: N=5, VAL=31, rst_i low 3 cycles then high -> data_o = 31, out_valid_o = 0, count_o = 0, in_ready_o = 1.
- Select and latency: data_i = {4,3,2,1}, DEPTH=2, out_ready_i = 1; accept with sel_i = 2 at edge 0 -> out_valid_o = 1, data_o = 3 after edge 1. Then sel_i = 0..3 on consecutive cycles -> outputs 1,2,3,4 back-to-back.
- Backpressure: out_ready_i = 0, push 3 words, DEPTH=2 -> count_o = 2 after two accepts, in_ready_o = 0, third word held. Raise out_ready_i for one cycle -> word 1 leaves, word 3 accepted same cycle, count_o stays 2, order preserved.
- Bubble collapse: DEPTH=3, one word in stage 0, out_ready_i = 0 -> after 2 cycles the word is in the last stage, in_ready_o stays 1 until count_o = 3.
- Clear versus accept: clr_i = 1 with in_valid_i = 1 and 2 words in flight -> next cycle count_o = 0, data_o = 31, out_valid_o = 0, input word not delivered.
- Async reset mid-stream and parity (macro defined): rst_i low between edges with words in flight -> outputs reset before the next edge. After release, push 5'b00111 -> parity_o = 1, parity_err_o = 0.
